fifo_read_serialiser: RTL and testbench

Drains the read side of a synchronous FIFO (first-word-fall-through: `fifo_rdata` is valid whenever `!fifo_empty`) and serialises each wide word into RATIO narrow slices on a valid/ready output stream. It sits between a wide-word producer's FIFO and a narrow consumer such as a byte-wide UART/SPI transmitter. Sustains one slice per cycle with no bubble between consecutive words.

---
 rtl/fifo_read_serialiser.sv | 101 ++++++++++
 tb/tb_fifo_read_serialiser.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_serialiser.sv
// Pops wide words from a first-word-fall-through FIFO and streams them as RATIO narrow slices.
// Latency: first slice valid the cycle after the pop; back-to-back words leave no bubble.
// Backpressure: out_ready low freezes every slice output; the pop for the next word waits for the final-slice handshake.
module fifo_read_serialiser #(
  parameter int W_OUT     = 8,
  parameter int RATIO     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [W_OUT*RATIO-1:0] fifo_rdata,
  input  logic                   fifo_empty,
  output logic                   fifo_ren,
  input  logic                   flush,
  output logic [W_OUT-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy
);

  localparam int W_IN  = W_OUT * RATIO;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [W_IN-1:0]   sreg_q, sreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              held;
  logic              xfer;

  assign held      = (state_q == SHIFT);
  assign out_valid = held;
  assign busy      = held;
  assign out_last  = held && (idx_q == LAST_IDX);
  assign xfer      = held && out_ready;

  // Next word is popped only when idle or when the final slice leaves this very cycle.
  assign fifo_ren  = rst_n && !flush && !fifo_empty && (!held || (xfer && out_last));

  generate
    if (LSB_FIRST) begin : g_lsb
      assign out_data = sreg_q[W_OUT-1:0];
    end else begin : g_msb
      assign out_data = sreg_q[W_IN-1 -: W_OUT];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    idx_d   = idx_q;
    if (flush) begin
      // Flush wins over any load or shift; the FIFO itself is left alone.
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_ren) begin
            sreg_d  = fifo_rdata;
            idx_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (idx_q != LAST_IDX) begin
              idx_d  = idx_q + IDX_W'(1);
              sreg_d = LSB_FIRST ? (sreg_q >> W_OUT) : (sreg_q << W_OUT);
            end else if (fifo_ren) begin
              sreg_d = fifo_rdata;
              idx_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_serialiser.sv
// Self-checking bench: directed scenarios on three configurations plus a randomized run against a slice-queue model.
module tb_fifo_read_serialiser;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] a_rdata; logic a_empty, a_ren, a_flush, a_ready, a_valid, a_last, a_busy; logic [7:0] a_data;
  logic [31:0] b_rdata; logic b_empty, b_ren, b_flush, b_ready, b_valid, b_last, b_busy; logic [7:0] b_data;
  logic [7:0]  c_rdata; logic c_empty, c_ren, c_flush, c_ready, c_valid, c_last, c_busy; logic [7:0] c_data;

  fifo_read_serialiser #(.W_OUT(8), .RATIO(4), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .fifo_rdata(a_rdata), .fifo_empty(a_empty), .fifo_ren(a_ren),
    .flush(a_flush), .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready),
    .out_last(a_last), .busy(a_busy));
  fifo_read_serialiser #(.W_OUT(8), .RATIO(4), .LSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .fifo_rdata(b_rdata), .fifo_empty(b_empty), .fifo_ren(b_ren),
    .flush(b_flush), .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .out_last(b_last), .busy(b_busy));
  fifo_read_serialiser #(.W_OUT(8), .RATIO(1), .LSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .fifo_rdata(c_rdata), .fifo_empty(c_empty), .fifo_ren(c_ren),
    .flush(c_flush), .out_data(c_data), .out_valid(c_valid), .out_ready(c_ready),
    .out_last(c_last), .busy(c_busy));

  int checks = 0;
  int errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [7:0]  qc[$];

  function automatic logic [7:0] sl(input logic [31:0] w, input int i);
    return w[8*i +: 8];
  endfunction

  function automatic void refresh();
    a_empty = (qa.size() == 0); a_rdata = a_empty ? 32'h0 : qa[0];
    b_empty = (qb.size() == 0); b_rdata = b_empty ? 32'h0 : qb[0];
    c_empty = (qc.size() == 0); c_rdata = c_empty ? 8'h0 : qc[0];
  endfunction

  task automatic push_a(input logic [31:0] w); qa.push_back(w); refresh(); endtask
  task automatic push_b(input logic [31:0] w); qb.push_back(w); refresh(); endtask
  task automatic push_c(input logic [7:0] w);  qc.push_back(w); refresh(); endtask

  // Advance one cycle; the bench FIFOs pop whatever was strobed at the edge.
  task automatic step();
    logic pa, pb, pc;
    pa = a_ren; pb = b_ren; pc = c_ren;
    @(negedge clk);
    if (pa && qa.size() > 0) void'(qa.pop_front());
    if (pb && qb.size() > 0) void'(qb.pop_front());
    if (pc && qc.size() > 0) void'(qc.pop_front());
    refresh();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_flush = 0; a_ready = 0; b_flush = 0; b_ready = 0; c_flush = 0; c_ready = 0;
    refresh();
    repeat (2) @(negedge clk);
    push_a(32'h12345678);
    #1;
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a_valid); end
    checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", a_data); end
    checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", a_last); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
    checks++; if (a_ren !== 1'b0) begin errors++; $display("FAIL reset_ren got %b want 0", a_ren); end
    checks++; if (b_valid !== 1'b0 || c_valid !== 1'b0) begin errors++; $display("FAIL reset_bc_valid got %b%b want 00", b_valid, c_valid); end
    qa.delete(); refresh();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int rens = 0;
    a_ready = 1;
    push_a(32'h44332211);
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (a_ren !== (c == 0)) begin errors++; $display("FAIL single_ren c=%0d got %b want %b", c, a_ren, (c == 0)); end
      checks++; if (a_valid !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL single_valid c=%0d got %b", c, a_valid); end
      if (c >= 1 && c <= 4) begin
        checks++; if (a_data !== sl(32'h44332211, c - 1)) begin errors++; $display("FAIL single_data c=%0d got %h want %h", c, a_data, sl(32'h44332211, c - 1)); end
        checks++; if (a_last !== (c == 4)) begin errors++; $display("FAIL single_last c=%0d got %b", c, a_last); end
      end
      if (a_ren) rens++;
      step();
    end
    checks++; if (rens != 1) begin errors++; $display("FAIL single_ren_count got %0d want 1", rens); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    a_ready = 1;
    push_a(32'hA3A2A1A0); push_a(32'hB3B2B1B0);
    for (int c = 0; c < 10; c++) begin
      #1;
      w = (c <= 4) ? 32'hA3A2A1A0 : 32'hB3B2B1B0;
      checks++; if (a_ren !== (c == 0 || c == 4)) begin errors++; $display("FAIL b2b_ren c=%0d got %b", c, a_ren); end
      checks++; if (a_valid !== (c >= 1 && c <= 8)) begin errors++; $display("FAIL b2b_valid c=%0d got %b", c, a_valid); end
      if (c >= 1 && c <= 8) begin
        checks++; if (a_data !== sl(w, (c - 1) % 4)) begin errors++; $display("FAIL b2b_data c=%0d got %h want %h", c, a_data, sl(w, (c - 1) % 4)); end
        checks++; if (a_last !== (c == 4 || c == 8)) begin errors++; $display("FAIL b2b_last c=%0d got %b", c, a_last); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int sidx[9] = '{-1, 0, 1, 1, 1, 1, 2, 3, -1};
    push_a(32'h44332211);
    for (int c = 0; c < 9; c++) begin
      a_ready = !(c >= 2 && c <= 4);
      #1;
      checks++; if (a_ren !== (c == 0)) begin errors++; $display("FAIL bp_ren c=%0d got %b", c, a_ren); end
      checks++; if (a_valid !== (sidx[c] >= 0)) begin errors++; $display("FAIL bp_valid c=%0d got %b", c, a_valid); end
      if (sidx[c] >= 0) begin
        checks++; if (a_data !== sl(32'h44332211, sidx[c])) begin errors++; $display("FAIL bp_data c=%0d got %h want %h", c, a_data, sl(32'h44332211, sidx[c])); end
        checks++; if (a_last !== (sidx[c] == 3)) begin errors++; $display("FAIL bp_last c=%0d got %b", c, a_last); end
      end
      step();
    end
    a_ready = 1;
  endtask

  task automatic test_flush();
    logic [7:0] dat[9] = '{8'h00, 8'h11, 8'h22, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
    logic [8:0] vld = 9'b0_1111_0110;
    push_a(32'h44332211); push_a(32'h88776655);
    for (int c = 0; c < 9; c++) begin
      a_ready = (c != 2);
      a_flush = (c == 2);
      #1;
      checks++; if (a_ren !== (c == 0 || c == 3)) begin errors++; $display("FAIL flush_ren c=%0d got %b", c, a_ren); end
      checks++; if (a_valid !== vld[c]) begin errors++; $display("FAIL flush_valid c=%0d got %b want %b", c, a_valid, vld[c]); end
      if (vld[c]) begin
        checks++; if (a_data !== dat[c]) begin errors++; $display("FAIL flush_data c=%0d got %h want %h", c, a_data, dat[c]); end
        checks++; if (a_last !== (c == 7)) begin errors++; $display("FAIL flush_last c=%0d got %b", c, a_last); end
      end
      step();
    end
    a_flush = 0; a_ready = 1;
  endtask

  task automatic test_msb_first();
    b_ready = 1;
    push_b(32'h44332211);
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (b_ren !== (c == 0)) begin errors++; $display("FAIL msb_ren c=%0d got %b", c, b_ren); end
      checks++; if (b_valid !== (c >= 1 && c <= 4)) begin errors++; $display("FAIL msb_valid c=%0d got %b", c, b_valid); end
      if (c >= 1 && c <= 4) begin
        checks++; if (b_data !== sl(32'h44332211, 4 - c)) begin errors++; $display("FAIL msb_data c=%0d got %h want %h", c, b_data, sl(32'h44332211, 4 - c)); end
        checks++; if (b_last !== (c == 4)) begin errors++; $display("FAIL msb_last c=%0d got %b", c, b_last); end
      end
      step();
    end
  endtask

  task automatic test_ratio1();
    logic [7:0] bytes_in[3] = '{8'h5A, 8'hC3, 8'h7E};
    c_ready = 1;
    for (int i = 0; i < 3; i++) push_c(bytes_in[i]);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (c_ren !== (c <= 2)) begin errors++; $display("FAIL r1_ren c=%0d got %b", c, c_ren); end
      checks++; if (c_valid !== (c >= 1 && c <= 3)) begin errors++; $display("FAIL r1_valid c=%0d got %b", c, c_valid); end
      if (c >= 1 && c <= 3) begin
        checks++; if (c_data !== bytes_in[c - 1]) begin errors++; $display("FAIL r1_data c=%0d got %h want %h", c, c_data, bytes_in[c - 1]); end
        checks++; if (c_last !== 1'b1) begin errors++; $display("FAIL r1_last c=%0d got %b want 1", c, c_last); end
      end
      step();
    end
  endtask

  // Model: the held word is a queue of slices still to be shown, front = presented slice.
  task automatic test_stress();
    logic [7:0] cur[$];
    logic exp_vld, exp_last, exp_ren, did_rst, rst_now;
    did_rst = 0;
    for (int i = 0; i < 800; i++) begin
      rst_now = 0;
      if ($urandom_range(2, 0) == 0 && qa.size() < 6) push_a($urandom);
      a_ready = ($urandom_range(3, 0) != 0);
      a_flush = ($urandom_range(19, 0) == 0);
      #1;
      exp_vld  = (cur.size() > 0);
      exp_last = (cur.size() == 1);
      exp_ren  = !a_flush && (qa.size() > 0) && (cur.size() == 0 || (a_ready && cur.size() == 1));
      checks++; if (a_valid !== exp_vld) begin errors++; $display("FAIL rnd_valid i=%0d got %b want %b", i, a_valid, exp_vld); end
      checks++; if (a_busy !== exp_vld) begin errors++; $display("FAIL rnd_busy i=%0d got %b want %b", i, a_busy, exp_vld); end
      checks++; if (a_last !== exp_last) begin errors++; $display("FAIL rnd_last i=%0d got %b want %b", i, a_last, exp_last); end
      checks++; if (a_ren !== exp_ren) begin errors++; $display("FAIL rnd_ren i=%0d got %b want %b", i, a_ren, exp_ren); end
      checks++; if (a_ren && a_empty) begin errors++; $display("FAIL rnd_ren_empty i=%0d got ren=1 empty=1 want no pop", i); end
      if (exp_vld) begin
        checks++; if (a_data !== cur[0]) begin errors++; $display("FAIL rnd_data i=%0d got %h want %h", i, a_data, cur[0]); end
      end
      if (!did_rst && i >= 400 && cur.size() >= 2 && !a_flush) begin
        rst_now = 1; did_rst = 1;
        rst_n = 1'b0;
        #1;
        checks++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b%b want 00", a_valid, a_busy); end
        checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", a_data); end
        checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL midrst_last got %b want 0", a_last); end
        checks++; if (a_ren !== 1'b0) begin errors++; $display("FAIL midrst_ren got %b want 0", a_ren); end
        cur.delete();
      end else if (a_flush) begin
        cur.delete();
      end else begin
        if (exp_vld && a_ready) void'(cur.pop_front());
        if (exp_ren) for (int k = 0; k < 4; k++) cur.push_back(sl(qa[0], k));
      end
      step();
      if (rst_now) rst_n = 1'b1;
    end
    checks++; if (!did_rst) begin errors++; $display("FAIL midrst_taken got 0 want 1"); end
    a_flush = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_msb_first();
    test_ratio1();
    test_stress();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
